// File: rtl/host_if_mux.sv
// Multi-host register-write front end: per-host FIFOs drained round-robin into one register-write strobe.
// Optional macro HOST_IF_WR_PACING_EN enforces PACE_CYCLES of write recovery after every data pop.
module host_if_mux #(
  parameter int N_HOSTS     = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int LGFIFO      = 4,
  parameter int PACE_CYCLES = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_HOSTS-1:0]           host_wr,
  input  logic [2*N_HOSTS-1:0]         host_addr,
  input  logic [DATA_WIDTH*N_HOSTS-1:0] host_din,
  input  logic [2*N_HOSTS-1:0]         host_rd_addr,
  output logic [DATA_WIDTH*N_HOSTS-1:0] host_dout,
  output logic [N_HOSTS-1:0]           host_full,
  output logic [N_HOSTS-1:0]           host_overflow,
  input  logic [DATA_WIDTH-1:0]        status,
  output logic                         reg_wr_valid,
  output logic                         reg_wr_bank,
  output logic [DATA_WIDTH-1:0]        reg_wr_address,
  output logic [DATA_WIDTH-1:0]        reg_wr_data
);

  localparam int DEPTH   = 1 << LGFIFO;
  localparam int ENTRY_W = DATA_WIDTH + 2;
  localparam int PTR_W   = (N_HOSTS > 1) ? $clog2(N_HOSTS) : 1;

  // Entry layout: {bank, a0, data}
  logic [ENTRY_W-1:0]    fifo_mem [N_HOSTS][DEPTH];
  logic [LGFIFO:0]       wr_ptr [N_HOSTS];
  logic [LGFIFO:0]       rd_ptr [N_HOSTS];
  logic [N_HOSTS-1:0]    fifo_empty;
  logic [N_HOSTS-1:0]    fifo_full;
  logic [N_HOSTS-1:0]    push;

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      cand;
  logic                  grant_valid;
  logic                  pace_ok;
  logic [ENTRY_W-1:0]    head_entry;

  logic                  pop_valid;
  logic [PTR_W-1:0]      pop_host;
  logic [ENTRY_W-1:0]    pop_entry;

  logic [N_HOSTS-1:0]    lat_bank;
  logic [DATA_WIDTH-1:0] lat_addr [N_HOSTS];

  always_comb begin
    for (int i = 0; i < N_HOSTS; i++) begin
      fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
      fifo_full[i]  = (wr_ptr[i][LGFIFO] != rd_ptr[i][LGFIFO]) &&
                      (wr_ptr[i][LGFIFO-1:0] == rd_ptr[i][LGFIFO-1:0]);
      push[i]       = host_wr[i] && !fifo_full[i];
    end
  end

  assign host_full = fifo_full;

`ifdef HOST_IF_WR_PACING_EN
  localparam int PACE_W = $clog2(PACE_CYCLES) + 1;
  logic [PACE_W-1:0] pace_cnt;
  assign pace_ok = (pace_cnt == '0);
`else
  logic unused_pace;
  assign pace_ok     = 1'b1;
  assign unused_pace = ^PACE_CYCLES;
`endif

  // Descending scan so the candidate closest to rr_ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = N_HOSTS - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr) + k) % N_HOSTS);
      if (!fifo_empty[cand]) begin
        grant_valid = pace_ok;
        grant_idx   = cand;
      end
    end
  end

  assign head_entry = fifo_mem[grant_idx][rd_ptr[grant_idx][LGFIFO-1:0]];

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_HOSTS; i++) begin
      if (push[i])
        fifo_mem[i][wr_ptr[i][LGFIFO-1:0]] <=
          {host_addr[2*i +: 2], host_din[DATA_WIDTH*i +: DATA_WIDTH]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_HOSTS; i++) begin
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        lat_addr[i] <= '0;
      end
      lat_bank       <= '0;
      host_overflow  <= '0;
      rr_ptr         <= '0;
      pop_valid      <= 1'b0;
      pop_host       <= '0;
      pop_entry      <= '0;
      reg_wr_valid   <= 1'b0;
      reg_wr_bank    <= 1'b0;
      reg_wr_address <= '0;
      reg_wr_data    <= '0;
`ifdef HOST_IF_WR_PACING_EN
      pace_cnt       <= '0;
`endif
    end else begin
      // Full is judged before any same-cycle pop, so a write to a full FIFO is always dropped.
      for (int i = 0; i < N_HOSTS; i++) begin
        if (push[i])
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        else if (host_wr[i])
          host_overflow[i] <= 1'b1;
      end

      if (grant_valid) begin
        rd_ptr[grant_idx] <= rd_ptr[grant_idx] + 1'b1;
        rr_ptr            <= PTR_W'((int'(grant_idx) + 1) % N_HOSTS);
      end
      pop_valid <= grant_valid;
      pop_host  <= grant_idx;
      pop_entry <= head_entry;

      reg_wr_valid <= 1'b0;
      if (pop_valid) begin
        if (pop_entry[DATA_WIDTH]) begin
          reg_wr_valid   <= 1'b1;
          reg_wr_bank    <= lat_bank[pop_host];
          reg_wr_address <= lat_addr[pop_host];
          reg_wr_data    <= pop_entry[DATA_WIDTH-1:0];
        end else begin
          lat_bank[pop_host] <= pop_entry[DATA_WIDTH+1];
          lat_addr[pop_host] <= pop_entry[DATA_WIDTH-1:0];
        end
      end

`ifdef HOST_IF_WR_PACING_EN
      if (grant_valid && head_entry[DATA_WIDTH])
        pace_cnt <= PACE_W'(PACE_CYCLES - 1);
      else if (pace_cnt != '0)
        pace_cnt <= pace_cnt - 1'b1;
`endif
    end
  end

  // Reads of any address other than 0 return all ones; software phase detection depends on it.
  for (genvar g = 0; g < N_HOSTS; g++) begin : g_dout
    assign host_dout[DATA_WIDTH*g +: DATA_WIDTH] =
      (host_rd_addr[2*g +: 2] == 2'b00) ? status : {DATA_WIDTH{1'b1}};
  end

endmodule

// File: tb/tb_host_if_mux.sv
// Self-checking bench for host_if_mux: queue-level reference model feeding a strobe scoreboard.
// Works with or without HOST_IF_WR_PACING_EN defined.
module tb_host_if_mux;

  localparam int NH    = 3;
  localparam int DW    = 8;
  localparam int LG    = 2;
  localparam int DEPTH = 4;
  localparam int PACE  = 32;
`ifdef HOST_IF_WR_PACING_EN
  localparam bit PACING = 1'b1;
`else
  localparam bit PACING = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [NH-1:0]     host_wr;
  logic [2*NH-1:0]   host_addr;
  logic [DW*NH-1:0]  host_din;
  logic [2*NH-1:0]   host_rd_addr;
  logic [DW*NH-1:0]  host_dout;
  logic [NH-1:0]     host_full;
  logic [NH-1:0]     host_overflow;
  logic [DW-1:0]     status;
  logic              reg_wr_valid;
  logic              reg_wr_bank;
  logic [DW-1:0]     reg_wr_address;
  logic [DW-1:0]     reg_wr_data;

  host_if_mux #(
    .N_HOSTS(NH), .DATA_WIDTH(DW), .LGFIFO(LG), .PACE_CYCLES(PACE)
  ) dut (
    .clk(clk), .reset(reset),
    .host_wr(host_wr), .host_addr(host_addr), .host_din(host_din),
    .host_rd_addr(host_rd_addr), .host_dout(host_dout),
    .host_full(host_full), .host_overflow(host_overflow),
    .status(status),
    .reg_wr_valid(reg_wr_valid), .reg_wr_bank(reg_wr_bank),
    .reg_wr_address(reg_wr_address), .reg_wr_data(reg_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          bank;
    logic          a0;
    logic [DW-1:0] data;
  } entry_t;

  typedef struct {
    int            cyc;
    logic          bank;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  entry_t        fq [NH][$];
  exp_t          expq [$];
  int            rr_m;
  logic          lat_bank_m [NH];
  logic [DW-1:0] lat_addr_m [NH];
  int            pace_m;
  logic [NH-1:0] ovf_m;

  int            cyc = 0;
  int            reset_edge = -1;
  bit            mon_en = 1'b0;
  int            checks = 0;
  int            errors = 0;
  logic          held_bank = 1'b0;
  logic [DW-1:0] held_addr = '0;
  logic [DW-1:0] held_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: what one clock edge does to the queues, given the inputs in front of it.
  task automatic modelEdge(input bit rst, input logic [NH-1:0] wr,
                           input logic [2*NH-1:0] addr, input logic [DW*NH-1:0] din);
    int edge_id;
    bit full_b [NH];
    int g;
    entry_t e;
    exp_t x;
    edge_id = cyc + 1;
    if (rst) begin
      for (int h = 0; h < NH; h++) begin
        fq[h].delete();
        lat_bank_m[h] = 1'b0;
        lat_addr_m[h] = '0;
      end
      rr_m   = 0;
      pace_m = 0;
      ovf_m  = '0;
      while (expq.size() > 0 && expq[expq.size()-1].cyc >= edge_id)
        void'(expq.pop_back());
      reset_edge = edge_id;
    end else begin
      for (int h = 0; h < NH; h++) full_b[h] = (fq[h].size() == DEPTH);
      if (pace_m == 0) begin
        g = -1;
        for (int k = 0; k < NH; k++)
          if (g < 0 && fq[(rr_m + k) % NH].size() > 0) g = (rr_m + k) % NH;
        if (g >= 0) begin
          e    = fq[g].pop_front();
          rr_m = (g + 1) % NH;
          if (e.a0) begin
            x.cyc  = edge_id + 1;
            x.bank = lat_bank_m[g];
            x.addr = lat_addr_m[g];
            x.data = e.data;
            expq.push_back(x);
            if (PACING) pace_m = PACE - 1;
          end else begin
            lat_bank_m[g] = e.bank;
            lat_addr_m[g] = e.data;
          end
        end
      end else begin
        pace_m--;
      end
      for (int h = 0; h < NH; h++) begin
        if (wr[h]) begin
          if (full_b[h]) ovf_m[h] = 1'b1;
          else begin
            e.bank = addr[2*h+1];
            e.a0   = addr[2*h];
            e.data = din[DW*h +: DW];
            fq[h].push_back(e);
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic [NH-1:0]    exp_full;
    logic [DW*NH-1:0] exp_dout;
    for (int h = 0; h < NH; h++) begin
      exp_full[h] = (fq[h].size() == DEPTH);
      exp_dout[DW*h +: DW] = (host_rd_addr[2*h +: 2] == 2'd0) ? status : 8'hFF;
    end
    checks++;
    if (host_full !== exp_full) begin
      errors++;
      $display("[TB] FAIL host_full cyc=%0d: got %b, expected %b", cyc, host_full, exp_full);
    end
    checks++;
    if (host_overflow !== ovf_m) begin
      errors++;
      $display("[TB] FAIL host_overflow cyc=%0d: got %b, expected %b", cyc, host_overflow, ovf_m);
    end
    checks++;
    if (host_dout !== exp_dout) begin
      errors++;
      $display("[TB] FAIL host_dout cyc=%0d: got %h, expected %h (rd_addr=%b status=%h)",
               cyc, host_dout, exp_dout, host_rd_addr, status);
    end
  endtask

  task automatic applyStimulus(input bit rst, input logic [NH-1:0] wr,
                               input logic [2*NH-1:0] addr, input logic [DW*NH-1:0] din);
    reset     = rst;
    host_wr   = wr;
    host_addr = addr;
    host_din  = din;
    status    = DW'($urandom);
    for (int h = 0; h < NH; h++) host_rd_addr[2*h +: 2] = 2'($urandom_range(0, 3));
    modelEdge(rst, wr, addr, din);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0);
  endtask

  task automatic write1(input int h, input logic bank, input logic a0, input logic [DW-1:0] data);
    logic [NH-1:0]    w;
    logic [2*NH-1:0]  a;
    logic [DW*NH-1:0] d;
    w = '0; a = '0; d = '0;
    w[h] = 1'b1;
    a[2*h +: 2] = {bank, a0};
    d[DW*h +: DW] = data;
    applyStimulus(1'b0, w, a, d);
  endtask

  function automatic bit modelIdle();
    bit r;
    r = (expq.size() == 0);
    for (int h = 0; h < NH; h++) if (fq[h].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain();
    for (int n = 0; n < 3000 && !modelIdle(); n++) idle(1);
    idle(3);
    checks++;
    if (!modelIdle()) begin
      errors++;
      $display("[TB] FAIL drain timeout: %0d strobes still pending, expected 0", expq.size());
    end
  endtask

  // Monitor: compares every DUT strobe against the scoreboard, and the held outputs otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc == reset_edge) begin
        held_bank = 1'b0;
        held_addr = '0;
        held_data = '0;
      end
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL missed strobe: expected at cyc=%0d, got no strobe", expq[0].cyc);
        void'(expq.pop_front());
      end
      checks++;
      if (reg_wr_valid === 1'b1) begin
        if (expq.size() == 0 || expq[0].cyc != cyc) begin
          errors++;
          $display("[TB] FAIL unexpected strobe cyc=%0d: got bank=%0b addr=%02h data=%02h, expected none",
                   cyc, reg_wr_bank, reg_wr_address, reg_wr_data);
        end else begin
          if (reg_wr_bank !== expq[0].bank || reg_wr_address !== expq[0].addr ||
              reg_wr_data !== expq[0].data) begin
            errors++;
            $display("[TB] FAIL strobe cyc=%0d: got bank=%0b addr=%02h data=%02h, expected bank=%0b addr=%02h data=%02h",
                     cyc, reg_wr_bank, reg_wr_address, reg_wr_data,
                     expq[0].bank, expq[0].addr, expq[0].data);
          end
          held_bank = expq[0].bank;
          held_addr = expq[0].addr;
          held_data = expq[0].data;
          void'(expq.pop_front());
        end
      end else if (reg_wr_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reg_wr_valid cyc=%0d: got %b, expected 0/1", cyc, reg_wr_valid);
      end else if (expq.size() > 0 && expq[0].cyc == cyc) begin
        errors++;
        $display("[TB] FAIL missing strobe cyc=%0d: got valid=0, expected data=%02h", cyc, expq[0].data);
        void'(expq.pop_front());
      end else if (reg_wr_bank !== held_bank || reg_wr_address !== held_addr ||
                   reg_wr_data !== held_data) begin
        errors++;
        $display("[TB] FAIL held outputs cyc=%0d: got bank=%0b addr=%02h data=%02h, expected bank=%0b addr=%02h data=%02h",
                 cyc, reg_wr_bank, reg_wr_address, reg_wr_data, held_bank, held_addr, held_data);
      end
    end
  end

  initial begin
    logic [NH-1:0]    w;
    logic [2*NH-1:0]  a;
    logic [DW*NH-1:0] d;

    reset = 1'b1; host_wr = '0; host_addr = '0; host_din = '0;
    host_rd_addr = '0; status = '0;
    for (int h = 0; h < NH; h++) begin
      lat_bank_m[h] = 1'b0;
      lat_addr_m[h] = '0;
    end
    rr_m = 0; pace_m = 0; ovf_m = '0;

    applyStimulus(1'b1, '0, '0, '0);
    mon_en = 1'b1;
    applyStimulus(1'b1, '0, '0, '0);

    $display("[TB] single write");
    write1(0, 1'b0, 1'b0, 8'hB0);
    write1(0, 1'b0, 1'b1, 8'h21);
    drain();

    $display("[TB] interleaved hosts");
    applyStimulus(1'b0, 3'b011, {2'b00, 2'b10, 2'b00}, {8'h00, 8'h40, 8'h20});
    applyStimulus(1'b0, 3'b011, {2'b00, 2'b01, 2'b01}, {8'h00, 8'h22, 8'h11});
    drain();

    $display("[TB] fairness");
    for (int r = 0; r < 4; r++)
      applyStimulus(1'b0, 3'b111, {2'b01, 2'b01, 2'b01},
                    {8'(8'h20 + r), 8'(8'h10 + r), 8'(8'h00 + r)});
    drain();

    $display("[TB] overflow");
    for (int r = 0; r < 6; r++)
      applyStimulus(1'b0, 3'b111, {2'b01, 2'b01, 2'b01},
                    {8'(8'hC0 + r), 8'(8'hB0 + r), 8'(8'hA0 + r)});
    drain();

    $display("[TB] reset mid-stream");
    write1(0, 1'b1, 1'b1, 8'h51);
    write1(0, 1'b1, 1'b1, 8'h52);
    write1(0, 1'b1, 1'b1, 8'h53);
    applyStimulus(1'b1, '0, '0, '0);
    idle(4);

    $display("[TB] pacing / back-to-back data");
    write1(1, 1'b1, 1'b0, 8'h33);
    write1(1, 1'b1, 1'b1, 8'h01);
    write1(1, 1'b1, 1'b1, 8'h02);
    write1(1, 1'b1, 1'b1, 8'h03);
    drain();

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      for (int h = 0; h < NH; h++) begin
        w[h] = ($urandom_range(0, 99) < 35);
        a[2*h +: 2] = 2'($urandom_range(0, 3));
        d[DW*h +: DW] = DW'($urandom);
      end
      applyStimulus($urandom_range(0, 199) == 0, w, a, d);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
